// File: rtl/ram_probe_pkg.sv
// Shared types and helpers for the memory size-probe / clear engine.
package ram_probe_pkg;

  // Controller states: probe writes, scrub, probe reads, then the clear stream.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_P_WR    = 3'd1,
    ST_SCRUB   = 3'd2,
    ST_P_RD    = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_GAP     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Probe point j: 0 for j=0, otherwise one of the top PROBES-1 address bits.
  // The caller truncates the result to its address width.
  function automatic logic [63:0] probe_addr(input int j, input int aw, input int probes);
    if (j == 0) begin
      return 64'd0;
    end
    return 64'd1 << (aw - probes + j);
  endfunction

  // Signature for probe j: base*(j+1) kept to dw+4 bits; the caller
  // truncates to the data width.
  function automatic logic [63:0] sig(input int j, input int sig_base, input int dw);
    logic [63:0] prod;
    logic [63:0] keep;
    prod = 64'(sig_base) * 64'(j + 1);
    keep = (64'd1 << (dw + 4)) - 64'd1;
    return prod & keep;
  endfunction

endpackage

// File: rtl/probe_clear_throttle.sv
// Idle-gap counter for the clear stream: loaded on each clear transfer,
// counts down while the controller sits in its gap state, and flags when
// the next clear request may be issued.
module probe_clear_throttle #(
  parameter int CLR_GAP = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_clear_en
);

  localparam int GW = (CLR_GAP > 1) ? $clog2(CLR_GAP) : 1;
  // Count runs LOAD_VAL..0, so the gap state lasts exactly CLR_GAP cycles.
  localparam logic [GW-1:0] LOAD_VAL = (CLR_GAP > 0) ? GW'(CLR_GAP - 1) : '0;

  logic [GW-1:0] r_cnt;

  // Reload on a clear transfer, otherwise count down while idling in the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_clear_en = (r_cnt == '0);

endmodule

// File: rtl/ram_probe_clear.sv
// Memory size probe followed by a throttled clear of the whole address
// space. Probe writes signatures at aliasing address bits, discharges the
// bus with a scrub write, reads back and reports per-probe matches, then
// streams fill writes once or forever.
module ram_probe_clear
  import ram_probe_pkg::*;
#(
  parameter int AW         = 27,
  parameter int DW         = 16,
  parameter int PROBES     = 3,
  parameter int SIG_BASE   = 1032,
  parameter int SCRUB_DATA = 12345,
  parameter int CLR_DATA   = 0,
  parameter int CLR_GAP    = 8,
  parameter int CONTINUOUS = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  output logic [PROBES-1:0] size_flags,
  output logic              probe_done,
  output logic              clear_busy,
  output logic [7:0]        pass_cnt
);

  localparam int              JW         = $clog2(PROBES);
  localparam logic [JW-1:0]   J_TOP      = JW'(PROBES - 1);
  localparam logic [AW-1:0]   SCRUB_ADDR = AW'(64'd1 << (AW - PROBES));
  localparam logic [DW-1:0]   SCRUB_WORD = DW'(SCRUB_DATA);
  localparam logic [DW-1:0]   CLR_WORD   = DW'(CLR_DATA);
  localparam logic [AW-1:0]   ADDR_LAST  = '1;

  state_t            r_state;
  logic [JW-1:0]     r_j;
  logic [AW-1:0]     r_addr;
  logic [PROBES-1:0] r_flags;
  logic              r_probe_done;
  logic [7:0]        r_pass_cnt;

  logic              w_valid;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_wdata;
  logic              w_xfer;
  logic              w_wrap;
  logic              w_in_gap;
  logic              w_gap_load;
  logic              w_gap_expired;
  logic [AW-1:0]     w_probe_addr;
  logic [DW-1:0]     w_sig;

  assign w_probe_addr = AW'(probe_addr(int'(r_j), AW, PROBES));
  assign w_sig        = DW'(sig(int'(r_j), SIG_BASE, DW));

  // Request is a pure function of state and the registered index/address,
  // so it holds steady until the controller accepts it.
  always_comb begin
    w_valid = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      ST_P_WR: begin
        w_valid = 1'b1;
        w_we    = 1'b1;
        w_addr  = w_probe_addr;
        w_wdata = w_sig;
      end
      ST_SCRUB: begin
        w_valid = 1'b1;
        w_we    = 1'b1;
        w_addr  = SCRUB_ADDR;
        w_wdata = SCRUB_WORD;
      end
      ST_P_RD: begin
        w_valid = 1'b1;
        w_addr  = w_probe_addr;
      end
      ST_CLEAR: begin
        w_valid = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_addr;
        w_wdata = CLR_WORD;
      end
      default: begin
      end
    endcase
  end

  assign w_xfer     = w_valid & mem_ready;
  assign w_wrap     = (r_addr == ADDR_LAST);
  assign w_in_gap   = (r_state == ST_GAP);
  assign w_gap_load = (r_state == ST_CLEAR) & w_xfer;

  probe_clear_throttle #(
    .CLR_GAP (CLR_GAP)
  ) u_throttle (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .i_load     (w_gap_load),
    .i_run      (w_in_gap),
    .o_clear_en (w_gap_expired)
  );

  // Main sequencer: probe writes, scrub, readback compare, clear stream.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_j          <= '0;
      r_addr       <= '0;
      r_flags      <= '0;
      r_probe_done <= 1'b0;
      r_pass_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_flags      <= '0;
            r_probe_done <= 1'b0;
            r_pass_cnt   <= '0;
            r_j          <= J_TOP;
            r_state      <= ST_P_WR;
          end
        end
        ST_P_WR: begin
          if (w_xfer) begin
            if (r_j == '0) begin
              r_state <= ST_SCRUB;
            end else begin
              r_j <= r_j - 1'b1;
            end
          end
        end
        ST_SCRUB: begin
          if (w_xfer) begin
            r_j     <= J_TOP;
            r_state <= ST_P_RD;
          end
        end
        ST_P_RD: begin
          if (w_xfer) begin
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            for (int p = 0; p < PROBES; p++) begin
              if (JW'(p) == r_j) begin
                r_flags[p] <= (mem_rdata == w_sig);
              end
            end
            if (r_j == '0) begin
              r_probe_done <= 1'b1;
              r_addr       <= '0;
              r_state      <= ST_CLEAR;
            end else begin
              r_j     <= r_j - 1'b1;
              r_state <= ST_P_RD;
            end
          end
        end
        ST_CLEAR: begin
          if (w_xfer) begin
            r_addr <= r_addr + 1'b1;
            if (w_wrap) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
            end
            if (w_wrap && (CONTINUOUS == 0)) begin
              r_state <= ST_DONE;
            end else if (CLR_GAP != 0) begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_gap_expired) begin
            r_state <= ST_CLEAR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_valid  = w_valid;
  assign mem_we     = w_we;
  assign mem_addr   = w_addr;
  assign mem_wdata  = w_wdata;
  assign size_flags = r_flags;
  assign probe_done = r_probe_done;
  assign clear_busy = (r_state == ST_CLEAR) || (r_state == ST_GAP);
  assign pass_cnt   = r_pass_cnt;

endmodule

// File: doc/ram_probe_clear.md
Name: ram_probe_clear

Overview:
Parametrised memory size-probe and scrub engine for the menu core; successor to the fixed three-point SDRAM check and endless clear loop.
- Detects installed memory size with an aliasing write/readback test over PROBES address bits.
- Then clears the whole address space with a throttled write stream, either once or continuously.
- Sits between core control logic (start, status to hps_io menumask) and a generic valid/ready memory controller front-end (SDRAM or DDR3 adapter).

Parameters:
AW, 27, word address width of the memory port.
DW, 16, data width.
PROBES, 3, number of probe points; equals width of size_flags; 2..AW-1.
SIG_BASE, 1032, signature base; probe j writes SIG_BASE*(j+1) truncated to DW.
SCRUB_DATA, 12345, value written to the scrub address to discharge the bus.
CLR_DATA, 0, fill value for the clear phase.
CLR_GAP, 8, idle cycles between clear transfers; 0 means back-to-back.
CONTINUOUS, 1, 1 = clear loops forever; 0 = stop after one pass.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins probe; honoured only in IDLE or DONE.
mem_valid  out  1  request valid.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  AW  word address.
mem_wdata  out  DW  write data.
mem_ready  in  1  controller accepts the request when valid&ready.
mem_rvalid  in  1  one-cycle read-data strobe.
mem_rdata  in  DW  read data, valid with mem_rvalid.
size_flags  out  PROBES  per-probe readback match.
probe_done  out  1  size_flags final; held until next start.
clear_busy  out  1  clear phase active.
pass_cnt  out  8  completed clear passes; wraps 255->0.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; internal address and gap counter 0. Assertion mid-transaction drops mem_valid immediately. A pending read response is ignored.
- Probe address A(j):
  - j=0: 0.
  - j>=1: 1<<(AW-PROBES+j).
  - Scrub address AS = 1<<(AW-PROBES).
- Handshake:
  - mem_valid, mem_we, mem_addr and mem_wdata stay stable from assertion until the cycle valid&ready=1.
  - mem_valid deasserts the cycle after transfer unless a new request follows.
  - At most one outstanding read; the FSM waits for mem_rvalid. mem_rvalid outside RD_WAIT is ignored.
- FSM:
  - IDLE: on start, clear size_flags, probe_done and pass_cnt; go to P_WR with j=PROBES-1.
  - P_WR: write SIG(j) to A(j). On transfer, if j=0 go to SCRUB, else j-1.
  - SCRUB: write SCRUB_DATA to AS. On transfer go to P_RD with j=PROBES-1.
  - P_RD: read A(j). On transfer go to RD_WAIT.
  - RD_WAIT: on mem_rvalid, size_flags[j] <= (mem_rdata==SIG(j)). If j=0, set probe_done and go to CLEAR with addr=0; else j-1, back to P_RD.
  - CLEAR: clear_busy=1; write CLR_DATA to addr. On transfer, addr+1 mod 2^AW, then go to GAP (or stay in CLEAR if CLR_GAP=0).
  - At addr wrap 2^AW-1 -> 0: pass_cnt+1. If CONTINUOUS=0, go to DONE instead.
  - GAP: count CLR_GAP cycles with mem_valid=0, then return to CLEAR.
  - DONE: clear_busy=0; probe_done and size_flags held; start restarts via the IDLE path.
- start outside IDLE/DONE is ignored.
- A start coincident with the final clear transfer takes DONE first; it is not honoured in that cycle.
- Widths: the SIG multiply is computed in DW+4 bits and truncated. The address counter is exactly AW bits and wraps naturally.

Decomposition:
- Package ram_probe_pkg: state enum; functions probe_addr(j, AW, PROBES) and sig(j, SIG_BASE, DW).
- One sub-module, probe_clear_throttle: gap counter producing a clear-request enable. All else stays in one FSM.

Test Plan (AW=6, PROBES=3, CLR_GAP=8; probe addresses 32/16/0, scrub 8; SIG = 1032/2064/3096):
- Full 64-word memory model, start -> write sequence 32:3096, 16:2064, 0:1032, 8:12345; reads 32, 16, 0; size_flags=3'b111 and probe_done=1 one cycle after the third rvalid.
- Model ignoring addr bit 5 (32 words) -> read of 32 returns 1032; size_flags=3'b011.
- mem_ready held low 5 cycles during the SCRUB write -> mem_valid/addr=8/wdata=12345 stable all 5 cycles; exactly one transfer.
- CONTINUOUS=0 -> exactly 64 clear writes of 0, addresses 0..63 in order, 9-cycle transfer spacing; then clear_busy=0 and pass_cnt=1.
- CONTINUOUS=1, 2 passes -> address 63 followed by 0; pass_cnt=2; start mid-clear is ignored.
- reset_n pulsed low during RD_WAIT, late rvalid arrives -> all outputs 0 in the same cycle; state IDLE; no flag update from the late rvalid.
